uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 7/8 data bits, optional even parity, 9600/115200 baud.
// Latency: o_Valid pulses one cycle after the stop-bit sample (mid stop bit), plus 2 sync cycles.
// Backpressure: none; o_Valid is a one-cycle pulse and the result fields hold until the next pulse.
//
// Ports: clock, reset (synchronous, active-high); i_ParityEn / i_Datalength / i_Baudrate frame
// config, latched at start detection; i_DataIn serial line (idle high); o_Data / o_ParityErr /
// o_FrameErr result, qualified by o_Valid; o_Busy high from start detection until back in IDLE.
// Build option: define UART_RX_MAJORITY_EN to vote each bit over the samples at H-1, H and H+1.
module uart_rx #(
    parameter int BAUD_9600_BIT_PER   = 5208,
    parameter int BAUD_115200_BIT_PER = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_ParityEn,
    input  logic       i_Datalength,
    input  logic       i_Baudrate,
    input  logic       i_DataIn,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_ParityErr,
    output logic       o_FrameErr,
    output logic       o_Busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t      state, state_nxt;
    logic        sync1, sync2, line;
    logic        par_en_q, len8_q, baud_q;
    logic [12:0] cnt, bit_per, half;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        par_acc, par_err_q;
    logic        samp_en, samp_bit, last_bit;
    logic        start_det, data_smp, par_smp, stop_smp;

    // Synchronizer presets to idle-high so line activity during reset is never seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= i_DataIn;
            sync2 <= sync1;
        end
    end
    assign line = sync2;

    // Bit timing always follows the baud selection captured at start detection.
    assign bit_per  = baud_q ? 13'(BAUD_115200_BIT_PER) : 13'(BAUD_9600_BIT_PER);
    assign half     = bit_per >> 1;
    // Index 6 ends a 7-bit word, index 7 an 8-bit word.
    assign last_bit = (bit_idx == {2'b11, len8_q});

`ifdef UART_RX_MAJORITY_EN
    logic vote_a, vote_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else begin
            if (cnt == half - 13'd1) vote_a <= line;
            if (cnt == half)         vote_b <= line;
        end
    end

    assign samp_en  = (cnt == half + 13'd1);
    assign samp_bit = (vote_a & vote_b) | (vote_a & line) | (vote_b & line);
`else
    assign samp_en  = (cnt == half);
    assign samp_bit = line;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // State changes happen at the sample point itself; the free-running counter then carries
    // straight on into the next bit interval, so every later sample stays mid-bit.
    always_comb begin
        state_nxt = state;
        o_Busy    = (state != IDLE);
        start_det = 1'b0;
        data_smp  = 1'b0;
        par_smp   = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                if (!line) begin
                    state_nxt = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (samp_en) state_nxt = samp_bit ? IDLE : DATA;
            end
            DATA: begin
                if (samp_en) begin
                    data_smp = 1'b1;
                    if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (samp_en) begin
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (samp_en) begin
                    stop_smp  = 1'b1;
                    // Returning to IDLE mid stop bit lets a back-to-back start edge be caught.
                    state_nxt = samp_bit ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (line) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            par_en_q    <= 1'b0;
            len8_q      <= 1'b0;
            baud_q      <= 1'b0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_acc     <= 1'b0;
            par_err_q   <= 1'b0;
            o_Data      <= '0;
            o_Valid     <= 1'b0;
            o_ParityErr <= 1'b0;
            o_FrameErr  <= 1'b0;
        end else begin
            o_Valid <= 1'b0;

            if (state == IDLE)       cnt <= '0;
            else if (cnt == bit_per) cnt <= '0;
            else                     cnt <= cnt + 13'd1;

            if (start_det) begin
                par_en_q  <= i_ParityEn;
                len8_q    <= i_Datalength;
                baud_q    <= i_Baudrate;
                bit_idx   <= '0;
                shreg     <= '0;     // leaves bit 7 at 0 for 7-bit words
                par_acc   <= 1'b0;
                par_err_q <= 1'b0;
            end

            if (data_smp) begin
                shreg[bit_idx] <= samp_bit;
                par_acc        <= par_acc ^ samp_bit;
                bit_idx        <= bit_idx + 3'd1;
            end

            // Even parity: received parity bit plus all data ones must be even.
            if (par_smp) par_err_q <= samp_bit ^ par_acc;

            if (stop_smp) begin
                o_Data      <= shreg;
                o_ParityErr <= par_en_q & par_err_q;
                o_FrameErr  <= ~samp_bit;
                o_Valid     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx framing, timing, parity, framing error and reset abort.
// Latency: measures o_Valid relative to o_Busy rise (start detection) against hand-derived counts.
// Backpressure: none; the serial driver is a free-running transmitter on i_DataIn.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int P96  = 1000;   // shortened 9600 bit period keeps the run short
    localparam int P115 = 434;
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC = 1;       // decision moves from H to H+1
`else
    localparam int DEC = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       i_ParityEn, i_Datalength, i_Baudrate, i_DataIn;
    logic [7:0] o_Data;
    logic       o_Valid, o_ParityErr, o_FrameErr, o_Busy;

    always #5 clock = ~clock;

    uart_rx #(
        .BAUD_9600_BIT_PER   (P96),
        .BAUD_115200_BIT_PER (P115)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_ParityEn   (i_ParityEn),
        .i_Datalength (i_Datalength),
        .i_Baudrate   (i_Baudrate),
        .i_DataIn     (i_DataIn),
        .o_Data       (o_Data),
        .o_Valid      (o_Valid),
        .o_ParityErr  (o_ParityErr),
        .o_FrameErr   (o_FrameErr),
        .o_Busy       (o_Busy)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0, v_cnt = 0, rise_cyc = 0, fall_cyc = 0, valid_cyc = 0;
    int   base;
    logic busy_prev = 1'b0;
    logic [7:0] rx_data[$];
    logic       rx_perr[$];
    logic       rx_ferr[$];
    logic [7:0] exp37[3];

    // Output monitor, sampled 1 ns after each rising edge.
    always @(posedge clock) begin
        #1;
        cyc++;
        if (o_Busy === 1'b1 && !busy_prev) rise_cyc = cyc;
        if (o_Busy !== 1'b1 && busy_prev)  fall_cyc = cyc;
        busy_prev = (o_Busy === 1'b1);
        if (o_Valid === 1'b1) begin
            v_cnt++;
            valid_cyc = cyc;
            rx_data.push_back(o_Data);
            rx_perr.push_back(o_ParityErr);
            rx_ferr.push_back(o_FrameErr);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at a falling clock edge; the stop level is left on the line.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input bit par_bit, input int per, input bit stop_bit);
        i_DataIn = 1'b0;
        repeat (per + 1) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            i_DataIn = d[i];
            repeat (per + 1) @(negedge clock);
        end
        if (par_en) begin
            i_DataIn = par_bit;
            repeat (per + 1) @(negedge clock);
        end
        i_DataIn = stop_bit;
        repeat (per + 1) @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"},  32'(o_Data),      32'h0);
        check_eq({tag, "_valid"}, 32'(o_Valid),     32'h0);
        check_eq({tag, "_perr"},  32'(o_ParityErr), 32'h0);
        check_eq({tag, "_ferr"},  32'(o_FrameErr),  32'h0);
        check_eq({tag, "_busy"},  32'(o_Busy),      32'h0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; i_DataIn = 1'b1;
        i_ParityEn = 1'b0; i_Datalength = 1'b1; i_Baudrate = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check_all_zero("reset");

        // 115200 8N1 0xA5: valid 9*435 + 217 + 1 cycles after start detection.
        base = v_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, P115, 1'b1);
        repeat (20) @(negedge clock);
        check_eq("a5_count", 32'(v_cnt - base), 32'd1);
        check_eq("a5_data",  32'(rx_data[base]), 32'hA5);
        check_eq("a5_perr",  32'(rx_perr[base]), 32'h0);
        check_eq("a5_ferr",  32'(rx_ferr[base]), 32'h0);
        check_eq("a5_latency", 32'(valid_cyc - rise_cyc), 32'(4133 + DEC));

        // 9600 7E1 0x35 (four ones -> parity 0), config flipped mid-frame must be ignored.
        i_Baudrate = 1'b0; i_Datalength = 1'b0; i_ParityEn = 1'b1;
        base = v_cnt;
        fork
            send_frame(8'h35, 7, 1'b1, 1'b0, P96, 1'b1);
            begin
                repeat (300) @(negedge clock);
                i_Baudrate = 1'b1; i_Datalength = 1'b1; i_ParityEn = 1'b0;
            end
        join
        i_Baudrate = 1'b0; i_Datalength = 1'b0; i_ParityEn = 1'b1;
        repeat (20) @(negedge clock);
        send_frame(8'h35, 7, 1'b1, 1'b1, P96, 1'b1);
        repeat (20) @(negedge clock);
        check_eq("p35_count", 32'(v_cnt - base), 32'd2);
        check_eq("p35_data0", 32'(rx_data[base]), 32'h35);
        check_eq("p35_perr0", 32'(rx_perr[base]), 32'h0);
        check_eq("p35_ferr0", 32'(rx_ferr[base]), 32'h0);
        check_eq("p35_data1", 32'(rx_data[base+1]), 32'h35);
        check_eq("p35_perr1", 32'(rx_perr[base+1]), 32'h1);

        // 100-cycle glitch at 115200: false start, busy for H+1 = 218 cycles.
        i_Baudrate = 1'b1; i_Datalength = 1'b1; i_ParityEn = 1'b0;
        base = v_cnt;
        i_DataIn = 1'b0;
        repeat (100) @(negedge clock);
        i_DataIn = 1'b1;
        repeat (400) @(negedge clock);
        check_eq("glitch_count", 32'(v_cnt - base), 32'd0);
        check_eq("glitch_busy_len", 32'(fall_cyc - rise_cyc), 32'(218 + DEC));

        // 8N1 0x3C with stop held low for two bit times.
        base = v_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, P115, 1'b0);
        repeat (P115 + 1) @(negedge clock);
        check_eq("fe_count", 32'(v_cnt - base), 32'd1);
        check_eq("fe_data",  32'(rx_data[base]), 32'h3C);
        check_eq("fe_ferr",  32'(rx_ferr[base]), 32'h1);
        check_eq("fe_perr",  32'(rx_perr[base]), 32'h0);
        check_eq("fe_busy_low_line", 32'(o_Busy), 32'h1);
        i_DataIn = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("fe_busy_sync", 32'(o_Busy), 32'h1);
        repeat (2) @(negedge clock);
        check_eq("fe_busy_idle", 32'(o_Busy), 32'h0);
        repeat (20) @(negedge clock);

        // Reset in the middle of data bit 4, with line activity during reset.
        base = v_cnt;
        exp37[0] = 8'hA5;
        i_DataIn = 1'b0;
        repeat (P115 + 1) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            i_DataIn = exp37[0][i];
            repeat (P115 + 1) @(negedge clock);
        end
        i_DataIn = exp37[0][4];
        repeat (200) @(negedge clock);
        reset = 1'b1;
        i_DataIn = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("rst_abort");
        i_DataIn = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (600) @(negedge clock);
        check_eq("rst_no_valid", 32'(v_cnt - base), 32'd0);
        check_eq("rst_busy", 32'(o_Busy), 32'h0);
        send_frame(8'h81, 8, 1'b0, 1'b0, P115, 1'b1);
        repeat (20) @(negedge clock);
        check_eq("r81_count", 32'(v_cnt - base), 32'd1);
        check_eq("r81_data",  32'(rx_data[base]), 32'h81);
        check_eq("r81_perr",  32'(rx_perr[base]), 32'h0);
        check_eq("r81_ferr",  32'(rx_ferr[base]), 32'h0);

        // Back-to-back 8E1 frames at 115200; all three have an even count of ones.
        i_Baudrate = 1'b1; i_Datalength = 1'b1; i_ParityEn = 1'b1;
        exp37[0] = 8'h00; exp37[1] = 8'hFF; exp37[2] = 8'h5A;
        base = v_cnt;
        for (int k = 0; k < 3; k++) send_frame(exp37[k], 8, 1'b1, 1'b0, P115, 1'b1);
        repeat (20) @(negedge clock);
        check_eq("b2b_count", 32'(v_cnt - base), 32'd3);
        if (v_cnt - base >= 3) begin
            for (int k = 0; k < 3; k++) begin
                check_eq($sformatf("b2b_data%0d", k), 32'(rx_data[base+k]), 32'(exp37[k]));
                check_eq($sformatf("b2b_perr%0d", k), 32'(rx_perr[base+k]), 32'h0);
                check_eq($sformatf("b2b_ferr%0d", k), 32'(rx_ferr[base+k]), 32'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
